directory_request_arbiter: RTL and testbench
============================================

Name: directory_request_arbiter

Overview:
- Serialises coherence requests from the two L1 caches onto the single request port of the L2 directory.
- Holds one pending request per L1 in a one-entry buffer.
- Picks the next request with write-back priority, then round-robin, and keeps exactly one directory transaction in flight.
- Completion is returned to the originating L1; a stuck directory is caught by a timeout.

Parameters:
- ADDR_W, 8, address width (directory tag/line address)
- DATA_W, 8, write-back data width
- MSG_W, 2, coherence message width
- TIMEOUT, 15, maximum cycles waiting for dir_done before abort (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  L1 #0 request present
- req0_ready  out  1  buffer #0 empty, request accepted on valid&ready
- req0_msg  in  MSG_W  00 none, 01 read miss, 10 write miss, 11 write-back
- req0_addr  in  ADDR_W  line address
- req0_data  in  DATA_W  write-back data (ignored unless msg=11)
- req1_valid/req1_ready/req1_msg/req1_addr/req1_data  same as #0, for L1 #1
- dir_start  out  1  one-cycle pulse launching a directory transaction
- dir_src  out  1  requester index of the current transaction
- dir_msg  out  MSG_W  message of the current transaction
- dir_addr  out  ADDR_W  address of the current transaction
- dir_data  out  DATA_W  data of the current transaction
- dir_done  in  1  directory completion pulse
- done0  out  1  one-cycle completion pulse to L1 #0
- done1  out  1  one-cycle completion pulse to L1 #1
- err  out  1  qualifies doneX: transaction aborted by timeout
- timeout_err  out  1  sticky timeout flag, cleared only by rst
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at clk edge):
  - state IDLE; both buffers invalid, so req0_ready=req1_ready=1.
  - last_grant=1, so requester 0 wins the first tie.
  - All dir_* outputs, done0, done1, err, timeout_err and busy are 0; the timeout counter is 0.
  - Reset mid-transaction discards everything in flight; no done pulse is generated.
- Buffers:
  - reqX_ready = !bufX_valid, a registered signal.
  - On valid&ready with msg != 00: capture msg/addr/data; bufX_valid=1 from the next cycle.
  - On valid&ready with msg == 00: the request is consumed and dropped; the buffer stays empty.
  - A buffer is cleared only in RELEASE for its own index. A new request is therefore accepted no earlier than the cycle after RELEASE.
- FSM:
  - IDLE: if any buffer is valid, select a winner, latch its fields into dir_*, and go to ISSUE. Otherwise stay.
  - Winner selection:
    - Exactly one buffer valid: that one wins.
    - Both valid, exactly one holding msg=11: the write-back wins.
    - Otherwise: the index != last_grant wins.
    - Identical addresses in both buffers get no special handling; the directory resolves them.
  - ISSUE: dir_start=1 for exactly one cycle; go to WAIT; counter cleared. A dir_done in this cycle is ignored.
  - WAIT:
    - dir_done=1: go to RELEASE, err_next=0.
    - Otherwise the counter increments. When counter == TIMEOUT-1 with no dir_done, go to RELEASE, err_next=1, timeout_err<=1.
  - RELEASE:
    - doneX=1 for dir_src only; err=err_next.
    - Clear buf[dir_src]; last_grant<=dir_src; go to IDLE.
- dir_src/msg/addr/data hold stable from ISSUE through RELEASE. They keep their last value in IDLE and are only meaningful when busy.
- Latency, uncontended:
  - Request accepted at edge N; buffer valid at N+1.
  - ISSUE in cycle N+2 (dir_start).
  - dir_done at earliest N+3.
  - doneX in the cycle after dir_done.
  - Minimum request-to-done: 4 cycles.
- Throughput: one transaction per 4 cycles minimum. Both requesters waiting alternate, except that a write-back pre-empts.
- A dir_done outside WAIT is ignored.

Decomposition:
- Package coherence_pkg:
  - Message encodings MSG_NONE=00, MSG_RDMISS=01, MSG_WRMISS=10, MSG_WB=11.
  - FSM state enum IDLE/ISSUE/WAIT/RELEASE.
  - Widths ADDR_W/DATA_W/MSG_W.
- Sub-module req_buffer (one-entry register with valid/ready), instantiated twice.
- Selection logic and FSM stay in the top module.

Test Plan:
- Single read: req0 msg=01 addr=8'h02; dir_done 3 cycles after dir_start.
  - Required: one dir_start with dir_src=0, dir_addr=02.
  - done0 pulses once with err=0; done1 never pulses.
- Tie after reset: req0 msg=01 addr=10 and req1 msg=10 addr=20 in the same cycle; directory answers each with dir_done 1 cycle after dir_start.
  - Required: req0 granted first, then req1.
  - A second simultaneous pair is then ordered req0 first again, since last_grant=1.
- Write-back priority: buf0 msg=01 addr=03 and buf1 msg=11 addr=01 data=18, with last_grant=1.
  - Required: req1 granted first with dir_data=18.
- Timeout: req1 msg=10 addr=05, dir_done never asserted.
  - Required: exactly 15 WAIT cycles, then done1=1 with err=1.
  - timeout_err stays 1 until rst; a following req0 is then serviced normally.
- Drop and backpressure:
  - req0 msg=00: no dir_start is issued.
  - A second req0 while buffer #0 is full: req0_ready=0 and the request is not captured.
- Reset mid-WAIT: rst during WAIT.
  - Required: no done pulse; all outputs 0; both readies 1 in the next cycle.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared coherence encodings, FSM states and widths for the directory request arbiter.
package coherence_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int MSG_W   = 2;
    localparam int NUM_REQ = 2;

    typedef enum logic [MSG_W-1:0] {
        MSG_NONE   = 2'b00,
        MSG_RDMISS = 2'b01,
        MSG_WRMISS = 2'b10,
        MSG_WB     = 2'b11
    } msg_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // Winner among the two buffers: a lone request wins, then a lone write-back,
    // otherwise whoever was not granted last. Only meaningful with a buffer valid.
    function automatic logic pickWinner(input logic [NUM_REQ-1:0] valid,
                                        input logic [NUM_REQ-1:0] isWb,
                                        input logic               lastGrant);
        if (valid == 2'b01) return 1'b0;
        if (valid == 2'b10) return 1'b1;
        if (isWb == 2'b01) return 1'b0;
        if (isWb == 2'b10) return 1'b1;
        return ~lastGrant;
    endfunction

endpackage

// File: rtl/req_buffer.sv
// One-entry request buffer between an L1 and the arbiter. Ready is simply the
// registered empty flag; MSG_NONE requests are consumed without being stored.
module req_buffer
    import coherence_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int MSG_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [MSG_W-1:0]  reqMsg,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    input  logic              clear,
    output logic              bufValid,
    output logic [MSG_W-1:0]  bufMsg,
    output logic [ADDR_W-1:0] bufAddr,
    output logic [DATA_W-1:0] bufData
);

    assign reqReady = !bufValid;

    // Capture a real request when empty; the arbiter empties it on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            bufValid <= 1'b0;
            bufMsg   <= '0;
            bufAddr  <= '0;
            bufData  <= '0;
        end else if (clear) begin
            bufValid <= 1'b0;
        end else if (reqValid && !bufValid && (reqMsg != MSG_W'(MSG_NONE))) begin
            bufValid <= 1'b1;
            bufMsg   <= reqMsg;
            bufAddr  <= reqAddr;
            bufData  <= reqData;
        end
    end

endmodule

// File: rtl/directory_request_arbiter.sv
// Serialises coherence requests from two L1 caches onto the single L2 directory
// port: write-back first, then round-robin, one transaction in flight, with a
// timeout abort if the directory never answers.
module directory_request_arbiter
    import coherence_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MSG_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [MSG_W-1:0]  req0_msg,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [MSG_W-1:0]  req1_msg,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              dir_start,
    output logic              dir_src,
    output logic [MSG_W-1:0]  dir_msg,
    output logic [ADDR_W-1:0] dir_addr,
    output logic [DATA_W-1:0] dir_data,
    input  logic              dir_done,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              timeout_err,
    output logic              busy
);

    logic [NUM_REQ-1:0]             reqValid, reqReady, bufValid, bufClear, isWb;
    logic [NUM_REQ-1:0][MSG_W-1:0]  reqMsg, bufMsg;
    logic [NUM_REQ-1:0][ADDR_W-1:0] reqAddr, bufAddr;
    logic [NUM_REQ-1:0][DATA_W-1:0] reqData, bufData;

    state_e     state;
    logic       lastGrant;
    logic       winner;
    logic [7:0] waitCnt;

    assign reqValid   = {req1_valid, req0_valid};
    assign reqMsg     = {req1_msg, req0_msg};
    assign reqAddr    = {req1_addr, req0_addr};
    assign reqData    = {req1_data, req0_data};
    assign req0_ready = reqReady[0];
    assign req1_ready = reqReady[1];

    for (genvar i = 0; i < NUM_REQ; i++) begin : gBuf
        req_buffer #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W),
            .MSG_W (MSG_W)
        ) uBuf (
            .clk     (clk),
            .rst     (rst),
            .reqValid(reqValid[i]),
            .reqReady(reqReady[i]),
            .reqMsg  (reqMsg[i]),
            .reqAddr (reqAddr[i]),
            .reqData (reqData[i]),
            .clear   (bufClear[i]),
            .bufValid(bufValid[i]),
            .bufMsg  (bufMsg[i]),
            .bufAddr (bufAddr[i]),
            .bufData (bufData[i])
        );
    end

    // Only the buffer that owns the finishing transaction is emptied.
    always_comb begin
        bufClear = '0;
        if (state == RELEASE) bufClear[dir_src] = 1'b1;
    end

    // Flag write-backs so they can jump the round-robin order.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) isWb[i] = (bufMsg[i] == MSG_W'(MSG_WB));
    end

    assign winner = pickWinner(bufValid, isWb, lastGrant);
    assign busy   = (state != IDLE);

    // Transaction FSM; every directory/L1 facing output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lastGrant   <= 1'b1;
            waitCnt     <= '0;
            dir_start   <= 1'b0;
            dir_src     <= 1'b0;
            dir_msg     <= '0;
            dir_addr    <= '0;
            dir_data    <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            dir_start <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bufValid) begin
                        dir_src   <= winner;
                        dir_msg   <= bufMsg[winner];
                        dir_addr  <= bufAddr[winner];
                        dir_data  <= bufData[winner];
                        dir_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // dir_done here belongs to nothing and is ignored
                    waitCnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (dir_done) begin
                        done0 <= ~dir_src;
                        done1 <= dir_src;
                        state <= RELEASE;
                    end else if (waitCnt == 8'(TIMEOUT - 1)) begin
                        done0       <= ~dir_src;
                        done1       <= dir_src;
                        err         <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                RELEASE: begin
                    lastGrant <= dir_src;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_directory_request_arbiter.sv
// Self-checking bench for directory_request_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_directory_request_arbiter;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_msg, req1_msg, dir_msg;
    logic [7:0] req0_addr, req0_data, req1_addr, req1_data, dir_addr, dir_data;
    logic       dir_start, dir_src, dir_done, done0, done1, err, timeout_err, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    directory_request_arbiter #(.ADDR_W(8), .DATA_W(8), .MSG_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_msg(req0_msg),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_msg(req1_msg),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .dir_start(dir_start), .dir_src(dir_src), .dir_msg(dir_msg),
        .dir_addr(dir_addr), .dir_data(dir_data), .dir_done(dir_done),
        .done0(done0), .done1(done1), .err(err), .timeout_err(timeout_err), .busy(busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        req0_valid = 0; req0_msg = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_msg = 0; req1_addr = 0; req1_data = 0;
        dir_done = 0;
    endtask

    task automatic do_reset();
        rst = 1; idleInputs();
        tick(); tick();
        rst = 0;
    endtask

    task automatic drive(input int idx, input logic [1:0] m, input logic [7:0] a, input logic [7:0] d);
        if (idx == 0) begin req0_valid = 1; req0_msg = m; req0_addr = a; req0_data = d; end
        else          begin req1_valid = 1; req1_msg = m; req1_addr = a; req1_data = d; end
    endtask

    // Acts as the directory: waits for dir_start, answers 'delay' cycles later
    // (0 = never), and reports what the arbiter launched and how it finished.
    task automatic serve(input int delay, output bit got, output logic src, output logic [1:0] msg,
                         output logic [7:0] addr, output logic [7:0] data,
                         output logic d0, output logic d1, output logic e, output int waits);
        got = 0; src = 0; msg = 0; addr = 0; data = 0; d0 = 0; d1 = 0; e = 0; waits = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (dir_start === 1'b1) begin
                got = 1; src = dir_src; msg = dir_msg; addr = dir_addr; data = dir_data;
            end else tick();
        end
        if (!got) return;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) begin
                d0 = done0; d1 = done1; e = err; waits = k - 1; dir_done = 0;
                return;
            end
            dir_done = (k == delay);
        end
        dir_done = 0;
    endtask

    function automatic int pick(bit v0, bit v1, logic [1:0] m0, logic [1:0] m1, bit lg);
        if (v0 != v1) return v1 ? 1 : 0;
        if ((m0 == 2'b11) != (m1 == 2'b11)) return (m1 == 2'b11) ? 1 : 0;
        return lg ? 0 : 1;
    endfunction

    task automatic test_reset();
        req0_valid = 1; req0_msg = 2'b01; req1_valid = 1; req1_msg = 2'b11;
        rst = 1; tick(); tick(); rst = 0; idleInputs();
        checks++;
        if ({req0_ready, req1_ready, dir_start, dir_src, dir_msg, dir_addr, dir_data,
             done0, done1, err, timeout_err, busy} !== {2'b11, 25'd0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b%b start=%b src=%b msg=%h addr=%h data=%h done=%b%b err=%b to=%b busy=%b want rdy=11 rest 0",
                     req0_ready, req1_ready, dir_start, dir_src, dir_msg, dir_addr, dir_data,
                     done0, done1, err, timeout_err, busy);
        end
    endtask

    task automatic test_single_read();
        bit got; logic s, d0, d1, e; logic [1:0] m; logic [7:0] a, d; int w, extra;
        do_reset();
        drive(0, 2'b01, 8'h02, 8'hAA); tick(); idleInputs();
        checks++;
        if (req0_ready !== 1'b0) begin failures++; $display("FAIL single_ready_low: got %b want 0", req0_ready); end
        serve(3, got, s, m, a, d, d0, d1, e, w);
        checks++;
        if ({got, s, m, a} !== {1'b1, 1'b0, 2'b01, 8'h02}) begin
            failures++; $display("FAIL single_issue: got start=%b src=%b msg=%h addr=%h want 1 0 1 02", got, s, m, a);
        end
        checks++;
        if ({d0, d1, e, w} !== {3'b100, 32'd3}) begin
            failures++; $display("FAIL single_done: got d0=%b d1=%b err=%b waits=%0d want 1 0 0 3", d0, d1, e, w);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin tick(); extra += int'(done0) + int'(done1) + int'(dir_start); end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL single_extra_pulses: got %0d want 0", extra); end
    endtask

    task automatic test_tie();
        bit got; logic s, d0, d1, e; logic [1:0] m; logic [7:0] a, d; int w;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(0, 2'b01, 8'h10 + 8'(r), 8'h00); drive(1, 2'b10, 8'h20 + 8'(r), 8'h00);
            tick(); idleInputs();
            serve(1, got, s, m, a, d, d0, d1, e, w);
            checks++;
            if ({got, s, m, a, d0, d1, e, w} !== {1'b1, 1'b0, 2'b01, 8'h10 + 8'(r), 3'b100, 32'd1}) begin
                failures++; $display("FAIL tie_first_r%0d: got start=%b src=%b msg=%h addr=%h d=%b%b err=%b w=%0d want src0 addr %h", r, got, s, m, a, d0, d1, e, w, 8'h10 + 8'(r));
            end
            serve(1, got, s, m, a, d, d0, d1, e, w);
            checks++;
            if ({got, s, m, a, d0, d1, e, w} !== {1'b1, 1'b1, 2'b10, 8'h20 + 8'(r), 3'b010, 32'd1}) begin
                failures++; $display("FAIL tie_second_r%0d: got start=%b src=%b msg=%h addr=%h d=%b%b err=%b w=%0d want src1 addr %h", r, got, s, m, a, d0, d1, e, w, 8'h20 + 8'(r));
            end
            tick();
        end
    endtask

    task automatic test_wb_priority();
        bit got; logic s, d0, d1, e; logic [1:0] m; logic [7:0] a, d; int w;
        do_reset();
        drive(0, 2'b01, 8'h03, 8'h00); drive(1, 2'b11, 8'h01, 8'h18);
        tick(); idleInputs();
        serve(2, got, s, m, a, d, d0, d1, e, w);
        checks++;
        if ({got, s, m, a, d, d1} !== {1'b1, 1'b1, 2'b11, 8'h01, 8'h18, 1'b1}) begin
            failures++; $display("FAIL wb_first: got start=%b src=%b msg=%h addr=%h data=%h done1=%b want src1 wb 01 18", got, s, m, a, d, d1);
        end
        serve(2, got, s, m, a, d, d0, d1, e, w);
        checks++;
        if ({got, s, m, a, d0} !== {1'b1, 1'b0, 2'b01, 8'h03, 1'b1}) begin
            failures++; $display("FAIL wb_second: got start=%b src=%b msg=%h addr=%h done0=%b want src0 rd 03", got, s, m, a, d0);
        end
    endtask

    task automatic test_timeout();
        bit got; logic s, d0, d1, e; logic [1:0] m; logic [7:0] a, d; int w;
        do_reset();
        drive(1, 2'b10, 8'h05, 8'h00); tick(); idleInputs();
        serve(0, got, s, m, a, d, d0, d1, e, w);
        checks++;
        if ({got, s, a, d0, d1, e, w, timeout_err} !== {1'b1, 1'b1, 8'h05, 3'b011, 32'd15, 1'b1}) begin
            failures++; $display("FAIL timeout_abort: got start=%b src=%b addr=%h d=%b%b err=%b waits=%0d to=%b want src1 d=01 err1 waits15 to1", got, s, a, d0, d1, e, w, timeout_err);
        end
        tick();
        drive(0, 2'b01, 8'h07, 8'h00); tick(); idleInputs();
        serve(2, got, s, m, a, d, d0, d1, e, w);
        checks++;
        if ({got, s, a, d0, e, w, timeout_err} !== {1'b1, 1'b0, 8'h07, 2'b10, 32'd2, 1'b1}) begin
            failures++; $display("FAIL timeout_after: got start=%b src=%b addr=%h d0=%b err=%b waits=%0d to=%b want src0 07 d0=1 err0 waits2 to1", got, s, a, d0, e, w, timeout_err);
        end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_sticky_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_drop_backpressure();
        bit got; logic s, d0, d1, e; logic [1:0] m; logic [7:0] a, d; int w, starts;
        do_reset();
        drive(0, 2'b00, 8'h55, 8'h00); tick(); idleInputs();
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            starts += int'(dir_start) + int'(!req0_ready);
            tick();
        end
        checks++;
        if (starts !== 0) begin failures++; $display("FAIL drop_none: got %0d starts/busy-buffer cycles want 0", starts); end
        drive(0, 2'b01, 8'h33, 8'h00); tick();
        drive(0, 2'b10, 8'h44, 8'h00);
        checks++;
        if (req0_ready !== 1'b0) begin failures++; $display("FAIL backpressure_ready: got %b want 0", req0_ready); end
        tick(); idleInputs();
        serve(2, got, s, m, a, d, d0, d1, e, w);
        checks++;
        if ({got, s, m, a, d0} !== {1'b1, 1'b0, 2'b01, 8'h33, 1'b1}) begin
            failures++; $display("FAIL backpressure_first: got start=%b src=%b msg=%h addr=%h d0=%b want src0 01 33", got, s, m, a, d0);
        end
        starts = 0;
        for (int i = 0; i < 8; i++) begin tick(); starts += int'(dir_start); end
        checks++;
        if (starts !== 0) begin failures++; $display("FAIL backpressure_not_captured: got %0d starts want 0", starts); end
    endtask

    task automatic test_reset_mid_wait();
        int pulses; bit seen;
        do_reset();
        drive(0, 2'b01, 8'h09, 8'h00); drive(1, 2'b10, 8'h0A, 8'h00); tick(); idleInputs();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (dir_start === 1'b1) seen = 1; else tick();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL midwait_start: got no dir_start want one"); end
        tick(); tick();
        rst = 1; dir_done = 1; tick(); rst = 0; dir_done = 0;
        checks++;
        if ({req0_ready, req1_ready, dir_start, dir_src, dir_msg, dir_addr, dir_data,
             done0, done1, err, timeout_err, busy} !== {2'b11, 25'd0}) begin
            failures++;
            $display("FAIL midwait_reset: got rdy=%b%b start=%b src=%b addr=%h done=%b%b err=%b busy=%b want rdy=11 rest 0",
                     req0_ready, req1_ready, dir_start, dir_src, dir_addr, done0, done1, err, busy);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin tick(); pulses += int'(done0) + int'(done1) + int'(dir_start); end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL midwait_quiet: got %0d pulses want 0", pulses); end
    endtask

    // Randomized traffic against a transaction model: buffers are single slots,
    // a launch follows any idle cycle with a pending slot, and each launch ends
    // one cycle after the directory answers or after TO cycles of silence.
    task automatic test_random();
        bit mV[2];
        logic [1:0] mM[2];
        logic [7:0] mA[2], mD[2];
        bit lg, inF, sticky, expStart, eErr;
        int eSrc, curSrc, startC, doneC, dly, nStarts;
        do_reset();
        mV[0] = 0; mV[1] = 0;
        lg = 1; inF = 0; sticky = 0; expStart = 0; eErr = 0;
        eSrc = 0; curSrc = 0; startC = 0; doneC = -1; dly = 0; nStarts = 0;
        for (int c = 0; c < 3000; c++) begin
            bit isDone, eD0, eD1, eTo, v;
            logic [1:0] m;
            logic [7:0] a, d;
            checks++;
            if ({req1_ready, req0_ready} !== {~mV[1], ~mV[0]}) begin
                failures++; $display("FAIL rnd_ready c=%0d: got %b%b want %b%b", c, req1_ready, req0_ready, ~mV[1], ~mV[0]);
            end
            checks++;
            if (dir_start !== expStart) begin
                failures++; $display("FAIL rnd_start c=%0d: got %b want %b", c, dir_start, expStart);
            end
            if (expStart && dir_start === 1'b1) begin
                checks++;
                if ({dir_src, dir_msg, dir_addr, dir_data} !== {eSrc[0], mM[eSrc], mA[eSrc], mD[eSrc]}) begin
                    failures++; $display("FAIL rnd_grant c=%0d: got src=%b msg=%h addr=%h data=%h want src=%0d msg=%h addr=%h data=%h",
                                         c, dir_src, dir_msg, dir_addr, dir_data, eSrc, mM[eSrc], mA[eSrc], mD[eSrc]);
                end
                inF = 1; curSrc = eSrc; startC = c; nStarts++;
                dly = $urandom_range(1, TO + 3);
                eErr = (dly > TO);
                doneC = c + ((dly < TO) ? dly : TO) + 1;
            end
            isDone = inF && (c == doneC);
            eD0 = isDone && (curSrc == 0);
            eD1 = isDone && (curSrc == 1);
            eTo = sticky || (isDone && eErr);
            checks++;
            if ({done1, done0, timeout_err, busy} !== {eD1, eD0, eTo, inF}) begin
                failures++; $display("FAIL rnd_status c=%0d: got done=%b%b to=%b busy=%b want done=%b%b to=%b busy=%b",
                                     c, done1, done0, timeout_err, busy, eD1, eD0, eTo, inF);
            end
            if (isDone) begin
                checks++;
                if (err !== eErr) begin failures++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, eErr); end
            end
            expStart = !inF && (mV[0] || mV[1]);
            if (expStart) eSrc = pick(mV[0], mV[1], mM[0], mM[1], lg);
            dir_done = (inF && !eErr && (c == startC + dly)) ||
                       ((!inF || c == startC || isDone) && ($urandom_range(0, 3) == 0));
            for (int x = 0; x < 2; x++) begin
                v = ($urandom_range(0, 9) < 4);
                m = 2'($urandom_range(0, 3));
                a = 8'($urandom_range(0, 3));
                d = 8'($urandom);
                if (x == 0) begin req0_valid = v; req0_msg = m; req0_addr = a; req0_data = d; end
                else        begin req1_valid = v; req1_msg = m; req1_addr = a; req1_data = d; end
                if (v && !mV[x] && m != 2'b00) begin mV[x] = 1; mM[x] = m; mA[x] = a; mD[x] = d; end
            end
            if (isDone) begin
                mV[curSrc] = 0; lg = curSrc[0]; inF = 0;
                if (eErr) sticky = 1;
            end
            tick();
        end
        idleInputs();
        checks++;
        if (nStarts < 20) begin failures++; $display("FAIL rnd_traffic: got %0d transactions want at least 20", nStarts); end
    endtask

    initial begin
        idleInputs();
        tick();
        test_reset();
        test_single_read();
        test_tie();
        test_wb_priority();
        test_timeout();
        test_drop_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
